// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - instruction stream and memory write bus bundle
// master = program source / memory side, slave = encoder-loader.
interface instr_encoder_loader_if #(parameter int AW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [4:0]    in_da;
  logic [4:0]    in_aa;
  logic [4:0]    in_ba;
  logic [14:0]   in_imm;
  logic          in_last;
  logic          mem_rdy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    output in_valid, in_op, in_da, in_aa, in_ba, in_imm, in_last, mem_rdy,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_da, in_aa, in_ba, in_imm, in_last, mem_rdy,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic instructions to IR words and streams them into instruction memory
// Optional illegal-op flagging: ILLEGAL_OP_CHK_EN.
module instr_encoder_loader #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  instr_encoder_loader_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   wrapped,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;
  state_t state_q, state_d;

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [AW-1:0] addr_q;
  logic          wrapped_q;

  logic [6:0]    opc;
  logic          imm_fmt;
  logic [31:0]   enc_word;
  logic          fifo_full, fifo_empty, writing, push, pop, begin_session;

  // Unknown op indices fall through to the NOP opcode with fields kept.
  always_comb begin
    opc     = 7'b0000000;
    imm_fmt = 1'b0;
    case (bus.in_op)
      5'd0:  opc = 7'b0000000;
      5'd1:  opc = 7'b0000010;
      5'd2:  opc = 7'b0000101;
      5'd3:  opc = 7'b1100101;
      5'd4:  opc = 7'b0001000;
      5'd5:  opc = 7'b0001010;
      5'd6:  opc = 7'b0001100;
      5'd7:  opc = 7'b0000001;
      5'd8:  opc = 7'b0100001;
      5'd9:  begin opc = 7'b0100010; imm_fmt = 1'b1; end
      5'd10: begin opc = 7'b0100101; imm_fmt = 1'b1; end
      5'd11: opc = 7'b0101110;
      5'd12: begin opc = 7'b0101000; imm_fmt = 1'b1; end
      5'd13: begin opc = 7'b0101010; imm_fmt = 1'b1; end
      5'd14: begin opc = 7'b0101100; imm_fmt = 1'b1; end
      5'd15: begin opc = 7'b1100010; imm_fmt = 1'b1; end
      5'd16: begin opc = 7'b1000101; imm_fmt = 1'b1; end
      5'd17: opc = 7'b1000000;
      5'd18: opc = 7'b0110010;
      5'd19: opc = 7'b0110001;
      5'd20: opc = 7'b1100001;
      5'd21: begin opc = 7'b0100000; imm_fmt = 1'b1; end
      5'd22: begin opc = 7'b1100000; imm_fmt = 1'b1; end
      5'd23: begin opc = 7'b1000100; imm_fmt = 1'b1; end
      5'd24: begin opc = 7'b0000111; imm_fmt = 1'b1; end
      default: opc = 7'b0000000;
    endcase
  end

  assign enc_word = {opc, bus.in_da, bus.in_aa,
                     imm_fmt ? bus.in_imm : {bus.in_ba, 10'b0}};

  assign fifo_full     = (count_q == (PW+1)'(DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign writing       = (state_q == LOAD) || (state_q == DRAIN);
  assign bus.in_ready  = (state_q == LOAD) && !fifo_full;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = writing && !fifo_empty && bus.mem_rdy;
  assign begin_session = (state_q == IDLE) && start;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign wrapped       = wrapped_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  if (push && bus.in_last) state_d = DRAIN;
      // mem_we high means the final pop is still on the bus this cycle.
      DRAIN: if (fifo_empty && !bus.mem_we) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      wrapped_q     <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      bus.mem_we <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        bus.mem_addr  <= addr_q;
        bus.mem_wdata <= fifo_q[rd_ptr_q];
        addr_q        <= addr_q + AW'(1);
        if (addr_q == '1) wrapped_q <= 1'b1;
      end
      if (begin_session) begin
        addr_q    <= start_addr;
        wrapped_q <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_OP_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (begin_session) begin
      err_q <= 1'b0;
    end else if (push && (bus.in_op > 5'd24)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized self-checking bench for instr_encoder_loader
// Expected words come from an op-table model; writes are captured and compared per session.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
`ifdef ILLEGAL_OP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, done, wrapped, err;

  instr_encoder_loader_if #(.AW(AW)) bus ();

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .bus(bus), .busy(busy), .done(done), .wrapped(wrapped), .err(err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rdy_viol = 0;
  logic last_rdy = 1'b0;
  bit rdy_rand = 1'b0;
  bit exp_err = 1'b0;
  int base = 0;

  typedef struct { bit [AW-1:0] addr; bit [31:0] data; int at; } wr_t;
  wr_t cap_q[$];
  bit [31:0] exp_q[$];
  int xfer_q[$];

  bit [6:0] opc_tab [25] = '{7'b0000000, 7'b0000010, 7'b0000101, 7'b1100101, 7'b0001000,
                             7'b0001010, 7'b0001100, 7'b0000001, 7'b0100001, 7'b0100010,
                             7'b0100101, 7'b0101110, 7'b0101000, 7'b0101010, 7'b0101100,
                             7'b1100010, 7'b1000101, 7'b1000000, 7'b0110010, 7'b0110001,
                             7'b1100001, 7'b0100000, 7'b1100000, 7'b1000100, 7'b0000111};
  int imm_ops [11] = '{9, 10, 12, 13, 14, 15, 16, 21, 22, 23, 24};

  function automatic bit [31:0] ref_word(input int op, input int da, input int aa,
                                         input int ba, input int imm);
    longint opc = 0;
    longint low = longint'(ba) * 1024;
    if (op <= 24) begin
      opc = longint'(opc_tab[op]);
      foreach (imm_ops[k]) if (imm_ops[k] == op) low = imm;
    end
    return 32'(opc * 33554432 + longint'(da) * 1048576 + longint'(aa) * 32768 + low);
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rdy <= bus.mem_rdy;
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      cap_q.push_back('{bus.mem_addr, bus.mem_wdata, cyc});
      if (last_rdy !== 1'b1) rdy_viol++;
    end
    if (rdy_rand) bus.mem_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic begin_session(input int addr);
    @(negedge clk);
    start = 1'b1;
    start_addr = AW'(addr);
    base = addr;
    exp_err = 1'b0;
    cap_q.delete();
    exp_q.delete();
    xfer_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int op, input int da, input int aa, input int ba,
                      input int imm, input bit last);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 5'(op); bus.in_da = 5'(da); bus.in_aa = 5'(aa); bus.in_ba = 5'(ba);
    bus.in_imm = 15'(imm); bus.in_last = last;
    while (bus.in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      exp_q.push_back(ref_word(op, da, aa, ba, imm));
      xfer_q.push_back(cyc);
      if (CHK && op > 24) exp_err = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic wait_done(output bit seen, output bit wr_at, output bit err_at, output bit after);
    int t = 0;
    seen = 0; wr_at = 0; err_at = 0; after = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (done !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done === 1'b1) begin
      seen = 1; wr_at = wrapped; err_at = err;
      @(negedge clk);
      after = done;
    end
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    obs = {bus.in_ready, bus.mem_we, busy, done, wrapped, err, 1'b0};
    compared++;
    if (obs !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_flags: {in_ready,mem_we,busy,done,wrapped,err}=%b required 000000", obs[6:1]);
    end
    compared++;
    if (bus.mem_addr !== '0) begin
      mismatched++; $display("FAIL reset_addr: got %h required 00", bus.mem_addr);
    end
    compared++;
    if (bus.mem_wdata !== 32'h0) begin
      mismatched++; $display("FAIL reset_wdata: got %h required 00000000", bus.mem_wdata);
    end
  endtask

  task automatic test_single_add;
    bit seen, wr_at, err_at, after;
    bus.mem_rdy = 1'b1;
    begin_session('h10);
    send(1, 3, 1, 2, 0, 1'b1);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (!seen || after !== 1'b0) begin
      mismatched++; $display("FAIL add_done_pulse: seen=%0d held=%0d required 1/0", seen, after);
    end
    compared++;
    if (cap_q.size() != 1) begin
      mismatched++; $display("FAIL add_count: got %0d writes required 1", cap_q.size());
    end else begin
      compared++;
      if (cap_q[0].addr !== 8'h10 || cap_q[0].data !== 32'h04308800 || exp_q[0] !== 32'h04308800) begin
        mismatched++;
        $display("FAIL add_word: got %h@%h model %h required 04308800@10", cap_q[0].data, cap_q[0].addr, exp_q[0]);
      end
      compared++;
      if (cap_q[0].at - xfer_q[0] != 2) begin
        mismatched++; $display("FAIL add_latency: got %0d cycles required 2", cap_q[0].at - xfer_q[0]);
      end
    end
    compared++;
    if (busy !== 1'b0 || wr_at !== 1'b0 || err_at !== 1'b0) begin
      mismatched++; $display("FAIL add_status: busy=%b wrapped=%b err=%b required 0/0/0", busy, wr_at, err_at);
    end
  endtask

  task automatic test_adi;
    bit seen, wr_at, err_at, after;
    begin_session('h20);
    send(9, 5, 5, 7, 'h1234, 1'b0);
    send(1, 5, 5, 7, 'h1234, 1'b1);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (cap_q.size() != 2) begin
      mismatched++; $display("FAIL adi_count: got %0d writes required 2", cap_q.size());
    end else begin
      compared++;
      if (cap_q[0].data !== 32'h44529234) begin
        mismatched++; $display("FAIL adi_word: got %h required 44529234", cap_q[0].data);
      end
      compared++;
      if (cap_q[1].data !== 32'h04529C00 || cap_q[1].data !== exp_q[1]) begin
        mismatched++; $display("FAIL add_imm_ignored: got %h required 04529c00", cap_q[1].data);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen, wr_at, err_at, after;
    begin_session('h40);
    for (int i = 0; i < 8; i++)
      send($urandom_range(0, 24), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 32767), i == 7);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (cap_q.size() != 8) begin
      mismatched++; $display("FAIL b2b_count: got %0d writes required 8", cap_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        compared++;
        if (cap_q[i].data !== exp_q[i] || cap_q[i].addr !== AW'(base + i) || cap_q[i].at != cap_q[0].at + i) begin
          mismatched++;
          $display("FAIL b2b_word%0d: got %h@%h cyc+%0d required %h@%h cyc+%0d", i,
                   cap_q[i].data, cap_q[i].addr, cap_q[i].at - cap_q[0].at, exp_q[i], AW'(base + i), i);
        end
      end
    end
  endtask

  task automatic test_stall;
    bit seen, wr_at, err_at, after;
    bus.mem_rdy = 1'b0;
    begin_session('h30);
    fork
      for (int i = 0; i < 10; i++)
        send($urandom_range(0, 24), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 32767), i == 9);
      begin
        repeat (8) @(negedge clk);
        compared++;
        if (exp_q.size() != DEPTH || cap_q.size() != 0 || bus.in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_hold: accepted=%0d writes=%0d in_ready=%b required %0d/0/0",
                   exp_q.size(), cap_q.size(), bus.in_ready, DEPTH);
        end
        bus.mem_rdy = 1'b1;
      end
    join
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (cap_q.size() != 10 || rdy_viol != 0) begin
      mismatched++; $display("FAIL stall_count: got %0d writes viol=%0d required 10/0", cap_q.size(), rdy_viol);
    end else begin
      for (int i = 0; i < 10; i++) begin
        compared++;
        if (cap_q[i].data !== exp_q[i] || cap_q[i].addr !== AW'(base + i)) begin
          mismatched++;
          $display("FAIL stall_word%0d: got %h@%h required %h@%h", i, cap_q[i].data, cap_q[i].addr, exp_q[i], AW'(base + i));
        end
      end
    end
  endtask

  task automatic test_wrap;
    bit seen, wr_at, err_at, after;
    begin_session('hFE);
    for (int i = 0; i < 3; i++) send(2, i, i + 1, i + 2, 0, i == 2);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (cap_q.size() != 3) begin
      mismatched++; $display("FAIL wrap_count: got %0d writes required 3", cap_q.size());
    end else begin
      compared++;
      if (cap_q[0].addr !== 8'hFE || cap_q[1].addr !== 8'hFF || cap_q[2].addr !== 8'h00) begin
        mismatched++;
        $display("FAIL wrap_addrs: got %h,%h,%h required fe,ff,00", cap_q[0].addr, cap_q[1].addr, cap_q[2].addr);
      end
    end
    compared++;
    if (!seen || wr_at !== 1'b1) begin
      mismatched++; $display("FAIL wrap_flag: done=%0d wrapped=%b required 1/1", seen, wr_at);
    end
  endtask

  task automatic test_reset_mid;
    bit seen, wr_at, err_at, after;
    bus.mem_rdy = 1'b0;
    begin_session('h50);
    for (int i = 0; i < 3; i++) send(4, i, i, i, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0 || bus.mem_addr !== '0) begin
      mismatched++;
      $display("FAIL midreset_state: busy=%b mem_we=%b in_ready=%b addr=%h required 0/0/0/00",
               busy, bus.mem_we, bus.in_ready, bus.mem_addr);
    end
    rst_n = 1'b1;
    bus.mem_rdy = 1'b1;
    repeat (6) @(negedge clk);
    compared++;
    if (cap_q.size() != 0) begin
      mismatched++; $display("FAIL midreset_flush: got %0d writes required 0", cap_q.size());
    end
    begin_session('h60);
    send(17, 6, 2, 3, 0, 1'b1);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (!seen || cap_q.size() != 1 || cap_q[0].addr !== 8'h60 || cap_q[0].data !== exp_q[0]) begin
      mismatched++; $display("FAIL midreset_restart: done=%0d writes=%0d required 1/1 at 60", seen, cap_q.size());
    end
  endtask

  task automatic test_illegal;
    bit seen, wr_at, err_at, after;
    begin_session('h70);
    send(27, 4, 9, 17, 'h7FFF, 1'b1);
    wait_done(seen, wr_at, err_at, after);
    compared++;
    if (cap_q.size() != 1 || cap_q[0].data !== 32'h0044C400) begin
      mismatched++; $display("FAIL illegal_word: writes=%0d required 1 word 0044c400", cap_q.size());
    end
    compared++;
    if (err_at !== CHK || err !== CHK) begin
      mismatched++; $display("FAIL illegal_err: at_done=%b idle=%b required %b", err_at, err, CHK);
    end
    begin_session('h78);
    compared++;
    if (err !== 1'b0) begin
      mismatched++; $display("FAIL illegal_err_clear: got %b required 0", err);
    end
    send(0, 0, 0, 0, 0, 1'b1);
    wait_done(seen, wr_at, err_at, after);
  endtask

  task automatic test_random;
    bit seen, wr_at, err_at, after;
    int n;
    rdy_rand = 1'b1;
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 12);
      begin_session((s % 2) ? $urandom_range(240, 255) : $urandom_range(0, 255));
      for (int i = 0; i < n; i++)
        send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 32767), i == n - 1);
      wait_done(seen, wr_at, err_at, after);
      compared++;
      if (!seen || cap_q.size() != n || wr_at !== (base + n >= 256) || err_at !== exp_err) begin
        mismatched++;
        $display("FAIL rand%0d_session: done=%0d writes=%0d wrapped=%b err=%b required 1/%0d/%b/%b",
                 s, seen, cap_q.size(), wr_at, err_at, n, base + n >= 256, exp_err);
      end else begin
        for (int i = 0; i < n; i++) begin
          compared++;
          if (cap_q[i].data !== exp_q[i] || cap_q[i].addr !== AW'(base + i)) begin
            mismatched++;
            $display("FAIL rand%0d_word%0d: got %h@%h required %h@%h", s, i,
                     cap_q[i].data, cap_q[i].addr, exp_q[i], AW'(base + i));
          end
        end
      end
    end
    rdy_rand = 1'b0;
    compared++;
    if (rdy_viol != 0) begin
      mismatched++; $display("FAIL rand_rdy_rule: %0d writes without prior mem_rdy required 0", rdy_viol);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_da = '0; bus.in_aa = '0;
    bus.in_ba = '0; bus.in_imm = '0; bus.in_last = 1'b0; bus.mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_single_add;
    test_adi;
    test_back_to_back;
    test_stall;
    test_wrap;
    test_reset_mid;
    bus.mem_rdy = 1'b1;
    test_illegal;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
